// File: rtl/mem_to_axi_bridge_pkg.sv
// System AXI types and widths shared between the memory-side masters and the
// system crossbar. The bridge and its order FIFO import this package.
package mem_to_axi_bridge_pkg;

    localparam int unsigned AxiAddrWidth     = 32;
    localparam int unsigned AxiDataWidth     = 128;
    localparam int unsigned AxiStrbWidth     = AxiDataWidth / 8;
    localparam int unsigned AxiSystemIdWidth = 6;
    localparam int unsigned AxiUserWidth     = 1;

    // Burst encodings (only INCR is ever issued by the bridge).
    localparam logic [1:0] BurstIncr = 2'b01;

    // Response encodings; bit 1 set marks SLVERR/DECERR.
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [AxiAddrWidth-1:0]     addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [5:0]                  atop;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_aw_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic [AxiStrbWidth-1:0] strb;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } axi_system_w_chan_t;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [1:0]                  resp;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_b_chan_t;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [AxiAddrWidth-1:0]     addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_ar_chan_t;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [AxiDataWidth-1:0]     data;
        logic [1:0]                  resp;
        logic                        last;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_r_chan_t;

    typedef struct packed {
        axi_system_aw_chan_t aw;
        logic                aw_valid;
        axi_system_w_chan_t  w;
        logic                w_valid;
        logic                b_ready;
        axi_system_ar_chan_t ar;
        logic                ar_valid;
        logic                r_ready;
    } axi_system_req_t;

    typedef struct packed {
        logic               aw_ready;
        logic               ar_ready;
        logic               w_ready;
        logic               b_valid;
        axi_system_b_chan_t b;
        logic               r_valid;
        axi_system_r_chan_t r;
    } axi_system_resp_t;

    // True for SLVERR and DECERR.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/mem_to_axi_bridge_order_fifo.sv
// Small FIFO remembering the kind (read/write) of every accepted request so
// that responses are retired in request order.
module mem_to_axi_bridge_order_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Depth-1:0]    mem_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Advance pointers and occupancy on push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Store the request kind at the write pointer.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; entries are only read while the count says they are valid.
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_to_axi_bridge.sv
// Memory-port (req/gnt/rvalid) to AXI4 master bridge. Every request becomes a
// single-beat AXI transaction with ID 0; responses return in request order.
// Optional feature: define MEM_TO_AXI_ERR_EN to report SLVERR/DECERR on
// mem_err_o; otherwise mem_err_o is tied low.
module mem_to_axi_bridge
    import mem_to_axi_bridge_pkg::*;
#(
    parameter int unsigned AddrWidth      = AxiAddrWidth,
    parameter int unsigned DataWidth      = AxiDataWidth,
    parameter int unsigned IdWidth        = AxiSystemIdWidth,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         axi_req_t      = axi_system_req_t,
    parameter type         axi_resp_t     = axi_system_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output axi_req_t               axi_req_o,
    input  axi_resp_t              axi_resp_i,
    output logic                   busy_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [2:0]  AxSize   = 3'($clog2(DataWidth / 8));

    logic                   ar_pend_q;
    logic                   aw_pend_q;
    logic                   w_pend_q;
    logic [AddrWidth-1:0]   ar_addr_q;
    logic [AddrWidth-1:0]   aw_addr_q;
    logic [DataWidth-1:0]   w_data_q;
    logic [DataWidth/8-1:0] w_strb_q;
    logic [CntWidth-1:0]    count_q;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic accept;
    logic r_ready;
    logic b_ready;
    logic r_hs;
    logic b_hs;
    logic retire;
    logic unused_resp;

    // A new request waits until every AXI request channel is idle and a slot is free.
    assign mem_gnt_o = mem_req_i & ~ar_pend_q & ~aw_pend_q & ~w_pend_q
                     & (count_q < CntWidth'(MaxOutstanding)) & ~fifo_full;
    assign accept    = mem_req_i & mem_gnt_o;

    // Only the response channel matching the oldest outstanding request is readied.
    assign r_ready = ~fifo_empty & ~fifo_head;
    assign b_ready = ~fifo_empty & fifo_head;
    assign r_hs    = axi_resp_i.r_valid & r_ready;
    assign b_hs    = axi_resp_i.b_valid & b_ready;
    assign retire  = r_hs | b_hs;

    mem_to_axi_bridge_order_fifo #(
        .Depth (MaxOutstanding)
    ) i_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (mem_we_i),
        .pop_i   (retire),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Capture the read address on accept; hold AR valid until the slave takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_pend_q <= 1'b0;
            ar_addr_q <= '0;
        end else if (accept && !mem_we_i) begin
            ar_pend_q <= 1'b1;
            ar_addr_q <= mem_addr_i;
        end else if (axi_resp_i.ar_ready) begin
            ar_pend_q <= 1'b0;
        end
    end

    // Capture the write address and beat; AW and W retire on their own handshakes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (accept && mem_we_i) begin
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
            aw_addr_q <= mem_addr_i;
            w_data_q  <= mem_wdata_i;
            w_strb_q  <= mem_strb_i;
        end else begin
            if (axi_resp_i.aw_ready) aw_pend_q <= 1'b0;
            if (axi_resp_i.w_ready)  w_pend_q  <= 1'b0;
        end
    end

    // Outstanding count: +1 on accept, -1 on retire, unchanged when both happen.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Assemble the AXI request from the registered channel state.
    always_comb begin
        // NOTE: default the whole struct first so no field can infer a latch.
        axi_req_o           = '0;
        axi_req_o.ar_valid  = ar_pend_q;
        axi_req_o.ar.addr   = ar_addr_q;
        axi_req_o.ar.size   = AxSize;
        axi_req_o.ar.burst  = BurstIncr;
        axi_req_o.aw_valid  = aw_pend_q;
        axi_req_o.aw.addr   = aw_addr_q;
        axi_req_o.aw.size   = AxSize;
        axi_req_o.aw.burst  = BurstIncr;
        axi_req_o.w_valid   = w_pend_q;
        axi_req_o.w.data    = w_data_q;
        axi_req_o.w.strb    = w_strb_q;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.r_ready   = r_ready;
        axi_req_o.b_ready   = b_ready;
    end

    assign mem_rvalid_o = retire;
    assign mem_rdata_o  = r_hs ? axi_resp_i.r.data : '0;
    assign busy_o       = (count_q != '0) | ar_pend_q | aw_pend_q | w_pend_q;

`ifdef MEM_TO_AXI_ERR_EN
    assign mem_err_o   = (r_hs & resp_is_err(axi_resp_i.r.resp))
                       | (b_hs & resp_is_err(axi_resp_i.b.resp));
    assign unused_resp = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                           axi_resp_i.b.id, axi_resp_i.b.user};
`else
    assign mem_err_o   = 1'b0;
    assign unused_resp = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                           axi_resp_i.r.resp, axi_resp_i.b.id, axi_resp_i.b.user,
                           axi_resp_i.b.resp};
`endif

`ifndef SYNTHESIS
    // A slave answering with nothing outstanding is a protocol violation.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_empty |-> !(axi_resp_i.r_valid || axi_resp_i.b_valid));

    // The outstanding count stays within its bound.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntWidth'(MaxOutstanding));
`endif

endmodule
